// File: rtl/sm2201_camac_pkg.sv
// Shared definitions for the SM2201 CAMAC cycle sequencer: state encoding,
// cycle timing constants and the cb_addr field layout.
package sm2201_camac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int SETUP_CYCLES   = 2;
  localparam int STROBE_MIN     = 2;
  localparam int TIMEOUT_CYCLES = 64;

  localparam int TIMER_W = 7;

  localparam int F_W    = 3;
  localparam int A_W    = 4;
  localparam int N_W    = 5;
  localparam int F_OFF  = 0;
  localparam int A_OFF  = F_OFF + F_W;
  localparam int N_OFF  = A_OFF + A_W;
  localparam int ADDR_W = N_OFF + N_W;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [N_W-1:0] n,
                                                  input logic [A_W-1:0] a,
                                                  input logic [F_W-1:0] f);
    logic [ADDR_W-1:0] addr;
    addr = {ADDR_W{1'b0}};
    addr[N_OFF +: N_W] = n;
    addr[A_OFF +: A_W] = a;
    addr[F_OFF +: F_W] = f;
    return addr;
  endfunction

endpackage

// File: rtl/sm2201_camac_cycle_sequencer_if.sv
// ISA-side request/response and CAMAC dataway signals of the cycle sequencer.
// slave = the sequencer, master = register decoder plus crate.
interface sm2201_camac_cycle_sequencer_if;
  logic        req_valid;
  logic        req_write;
  logic [4:0]  req_station;
  logic [3:0]  req_subaddr;
  logic [2:0]  req_func;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_timeout;
  logic        isa_chrdy;
  logic        q_r_debug;
  logic [11:0] cb_addr;
  logic [15:0] cb_data_out;
  logic        cb_data_oe;
  logic [15:0] cb_data_in;
  logic        cb_cx1;
  logic        cb_prr;

  modport slave (
    input  req_valid, req_write, req_station, req_subaddr, req_func, req_wdata,
    input  cb_data_in, cb_prr,
    output req_ready, rsp_valid, rsp_data, rsp_timeout, isa_chrdy, q_r_debug,
    output cb_addr, cb_data_out, cb_data_oe, cb_cx1
  );

  modport master (
    output req_valid, req_write, req_station, req_subaddr, req_func, req_wdata,
    output cb_data_in, cb_prr,
    input  req_ready, rsp_valid, rsp_data, rsp_timeout, isa_chrdy, q_r_debug,
    input  cb_addr, cb_data_out, cb_data_oe, cb_cx1
  );
endinterface

// File: rtl/sm2201_cycle_timer.sv
// Loadable down-counter that saturates at zero; paces SETUP, STROBE and the watchdog.
module sm2201_cycle_timer
  import sm2201_camac_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic [TIMER_W-1:0] count,
  output logic               zero
);

  logic [TIMER_W-1:0] count_r;

  // count register: load wins, otherwise decrement until zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {TIMER_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {TIMER_W{1'b0}}) begin
      count_r <= count_r - {{(TIMER_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == {TIMER_W{1'b0}});

endmodule

// File: rtl/sm2201_camac_cycle_sequencer.sv
// CAMAC dataway cycle sequencer (IDLE/SETUP/STROBE/HOLD/DONE) for an ISA host.
// Define SM2201_CAMAC_TIMEOUT_EN to build the STROBE watchdog.
module sm2201_camac_cycle_sequencer
  import sm2201_camac_pkg::*;
(
  input  logic isa_clk,
  input  logic isa_reset,
  sm2201_camac_cycle_sequencer_if.slave bus
);

  localparam logic [TIMER_W-1:0] SETUP_LOAD = TIMER_W'(SETUP_CYCLES - 1);
`ifdef SM2201_CAMAC_TIMEOUT_EN
  // One counter covers both the minimum dwell and the watchdog.
  localparam logic [TIMER_W-1:0] STROBE_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] MIN_LEFT    = TIMER_W'(TIMEOUT_CYCLES - STROBE_MIN);
`else
  localparam logic [TIMER_W-1:0] STROBE_LOAD = TIMER_W'(STROBE_MIN - 1);
  localparam logic [TIMER_W-1:0] MIN_LEFT    = {TIMER_W{1'b0}};
`endif

  state_e             state_r, state_next_s;
  logic               accept_s, capture_s, timeout_hit_s;
  logic               busy_next_s, wr_next_s;
  logic               timer_load_s, timer_zero_s, min_met_s, expired_s;
  logic [TIMER_W-1:0] timer_load_val_s, timer_count_s;
  logic               write_r, cap_valid_unused_s;
  logic [15:0]        cap_data_r, rsp_data_r, cb_data_out_r;
  logic [11:0]        cb_addr_r;
  logic               req_ready_r, rsp_valid_r, isa_chrdy_r, cb_cx1_r, cb_data_oe_r, q_r_debug_r;

  assign timer_load_s     = accept_s | ((state_r == ST_SETUP) & timer_zero_s);
  assign timer_load_val_s = accept_s ? SETUP_LOAD : STROBE_LOAD;
  assign min_met_s        = (timer_count_s <= MIN_LEFT);
  assign cap_valid_unused_s = 1'b0;
`ifdef SM2201_CAMAC_TIMEOUT_EN
  assign expired_s = timer_zero_s;
`else
  assign expired_s = 1'b0;
`endif

  sm2201_cycle_timer u_timer (
    .clk      (isa_clk),
    .rst_n    (isa_reset),
    .load     (timer_load_s),
    .load_val (timer_load_val_s),
    .count    (timer_count_s),
    .zero     (timer_zero_s)
  );

  // state register
  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next-state and per-transition control; the crate answering beats the watchdog
  always_comb begin
    state_next_s  = state_r;
    accept_s      = 1'b0;
    capture_s     = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_next_s = ST_SETUP;
          accept_s     = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (timer_zero_s) begin
          state_next_s = ST_STROBE;
        end else begin
          state_next_s = ST_SETUP;
        end
      end
      ST_STROBE: begin
        if (min_met_s && !bus.cb_prr) begin
          state_next_s = ST_HOLD;
          capture_s    = 1'b1;
        end else if (expired_s) begin
          state_next_s  = ST_HOLD;
          capture_s     = 1'b1;
          timeout_hit_s = 1'b1;
        end else begin
          state_next_s = ST_STROBE;
        end
      end
      ST_HOLD:  state_next_s = ST_DONE;
      ST_DONE:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
    busy_next_s = (state_next_s == ST_SETUP) || (state_next_s == ST_STROBE) ||
                  (state_next_s == ST_HOLD);
    wr_next_s   = accept_s ? bus.req_write : write_r;
  end

  // outputs registered from the upcoming state so they align with it
  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      req_ready_r   <= 1'b1;
      isa_chrdy_r   <= 1'b1;
      cb_cx1_r      <= 1'b1;
      rsp_valid_r   <= 1'b0;
      cb_data_oe_r  <= 1'b0;
      q_r_debug_r   <= 1'b0;
      write_r       <= 1'b0;
      cb_addr_r     <= 12'h000;
      cb_data_out_r <= 16'h0000;
      cap_data_r    <= 16'h0000;
      rsp_data_r    <= 16'h0000;
    end else begin
      req_ready_r  <= (state_next_s == ST_IDLE);
      isa_chrdy_r  <= ~busy_next_s;
      cb_cx1_r     <= (state_next_s != ST_STROBE);
      rsp_valid_r  <= (state_next_s == ST_DONE);
      cb_data_oe_r <= busy_next_s & wr_next_s;
      q_r_debug_r  <= busy_next_s & wr_next_s;
      write_r      <= wr_next_s;
      if (accept_s) begin
        cb_addr_r     <= pack_addr(bus.req_station, bus.req_subaddr, bus.req_func);
        cb_data_out_r <= bus.req_write ? bus.req_wdata : 16'h0000;
      end else if (!busy_next_s) begin
        cb_addr_r     <= 12'h000;
        cb_data_out_r <= 16'h0000;
      end else begin
        cb_addr_r     <= cb_addr_r;
        cb_data_out_r <= cb_data_out_r;
      end
      if (capture_s) begin
        cap_data_r <= timeout_hit_s ? 16'hFFFF : (write_r ? rsp_data_r : bus.cb_data_in);
      end else begin
        cap_data_r <= cap_data_r;
      end
      // response data only changes when DONE is presented
      if (state_next_s == ST_DONE) begin
        rsp_data_r <= cap_data_r;
      end else begin
        rsp_data_r <= rsp_data_r;
      end
    end
  end

`ifdef SM2201_CAMAC_TIMEOUT_EN
  logic cap_to_r, rsp_timeout_r;

  // timeout flag follows the same capture-then-present path as the data
  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      cap_to_r      <= 1'b0;
      rsp_timeout_r <= 1'b0;
    end else begin
      cap_to_r      <= capture_s ? timeout_hit_s : cap_to_r;
      rsp_timeout_r <= (state_next_s == ST_DONE) ? cap_to_r : rsp_timeout_r;
    end
  end

  assign bus.rsp_timeout = rsp_timeout_r | cap_valid_unused_s;
`else
  assign bus.rsp_timeout = cap_valid_unused_s;
`endif

  assign bus.req_ready   = req_ready_r;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_data    = rsp_data_r;
  assign bus.isa_chrdy   = isa_chrdy_r;
  assign bus.q_r_debug   = q_r_debug_r;
  assign bus.cb_addr     = cb_addr_r;
  assign bus.cb_data_out = cb_data_out_r;
  assign bus.cb_data_oe  = cb_data_oe_r;
  assign bus.cb_cx1      = cb_cx1_r;

endmodule
